// File: rtl/sync_delay_stage.sv
// sync_delay_stage: clocked matched-delay element for a 2-phase handshake channel.
// Upstream requests (inR transitions) are synchronized and detected against a
// reference level, and the block waits delay_cfg extra cycles before toggling
// outR. When a downstream acknowledge (inA transition) arrives, the block toggles
// outA upstream. The protocol error flags are sticky until reset.
module sync_delay_stage #(
   parameter int DLY_W       = 8,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inR,
   output logic             outA,
   output logic             outR,
   input  logic             inA,
   input  logic [DLY_W-1:0] delay_cfg,
   output logic             busy,
   output logic             err_overrun,
   output logic             err_ack,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_DLY = 2'd1,
      S_WAIT_ACK = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync_r;
   logic [SYNC_STAGES-1:0] r_sync_a;
   state_t                 r_state;
   logic [DLY_W-1:0]       r_cnt;
   logic                   r_ref;
   logic                   r_a_ref;
   logic                   r_out_r;
   logic                   r_out_a;
   logic                   r_busy;
   logic                   r_err_ovr;
   logic                   r_err_ack;
   logic [CNT_W-1:0]       r_done;

   logic w_s_r;
   logic w_s_a;
   logic w_req_evt;
   logic w_ack_evt;

   // Shift both asynchronous inputs through their synchronizer chains.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync_r <= '0;
         r_sync_a <= '0;
      end else begin
         r_sync_r <= {r_sync_r[SYNC_STAGES-2:0], inR};
         r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], inA};
      end
   end

   assign w_s_r     = r_sync_r[SYNC_STAGES-1];
   assign w_s_a     = r_sync_a[SYNC_STAGES-1];
   // A transition is any difference between the synchronized level and the last consumed level.
   assign w_req_evt = (w_s_r != r_ref);
   assign w_ack_evt = (w_s_a != r_a_ref);

   // Handshake FSM: it accepts a request, counts down the delay, issues outR, and waits for the ack.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_ref     <= 1'b0;
         r_a_ref   <= 1'b0;
         r_out_r   <= 1'b0;
         r_out_a   <= 1'b0;
         r_busy    <= 1'b0;
         r_err_ovr <= 1'b0;
         r_err_ack <= 1'b0;
         r_done    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req_evt) begin
                  r_ref   <= w_s_r;
                  r_cnt   <= delay_cfg;
                  r_state <= S_WAIT_DLY;
                  r_busy  <= 1'b1;
               end
               // Nothing is outstanding, so the ack is spurious. Consume it so that it is not reported again.
               if (w_ack_evt) begin
                  r_err_ack <= 1'b1;
                  r_a_ref   <= w_s_a;
               end
            end
            S_WAIT_DLY: begin
               // Do not queue an early request. It stays pending in r_ref and is accepted later in IDLE.
               if (w_req_evt) begin
                  r_err_ovr <= 1'b1;
               end
               if (w_ack_evt) begin
                  r_err_ack <= 1'b1;
                  r_a_ref   <= w_s_a;
               end
               if (r_cnt == '0) begin
                  r_out_r <= ~r_out_r;
                  r_state <= S_WAIT_ACK;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_WAIT_ACK: begin
               if (w_req_evt) begin
                  r_err_ovr <= 1'b1;
               end
               if (w_ack_evt) begin
                  r_a_ref <= w_s_a;
                  r_out_a <= ~r_out_a;
                  r_done  <= r_done + 1'b1;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign outR        = r_out_r;
   assign outA        = r_out_a;
   assign busy        = r_busy;
   assign err_overrun = r_err_ovr;
   assign err_ack     = r_err_ack;
   assign done_cnt    = r_done;

endmodule

// File: tb/tb_sync_delay_stage.sv
// tb_sync_delay_stage: directed checks of the sync_delay_stage 2-phase delay element.
// CNT_W is reduced to 4 so that the wrap of the handshake counter can be reached.
module tb_sync_delay_stage;

   localparam int DW   = 8;
   localparam int CW   = 4;
   localparam int SYNC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_r;
   logic          in_a;
   logic [DW-1:0] dly;
   logic          out_r;
   logic          out_a;
   logic          busy;
   logic          err_ovr;
   logic          err_ack;
   logic [CW-1:0] done_cnt;

   int total = 0;
   int bad   = 0;
   int exp_done = 0;

   sync_delay_stage #(
      .DLY_W(DW),
      .CNT_W(CW),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .inR(in_r),
      .outA(out_a),
      .outR(out_r),
      .inA(in_a),
      .delay_cfg(dly),
      .busy(busy),
      .err_overrun(err_ovr),
      .err_ack(err_ack),
      .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          in_r;
      logic          in_a;
      logic [DW-1:0] dly;
      int            cycles;
      logic          exp_out_r;
      logic          exp_out_a;
      logic          exp_busy;
      int            exp_done;
      string         name;
   } vec_t;

   vec_t vecs[14];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end else begin
         $display("ok   %s: %0d", nm, act);
      end
   endtask

   task automatic do_reset();
      rst  = 1'b0;
      in_r = 1'b0;
      in_a = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
      exp_done = 0;
   endtask

   // A full handshake: toggle inR, time outR, toggle inA, time outA.
   task automatic do_handshake(input int d, input string tag);
      logic prev;
      int   n;
      dly  = d[DW-1:0];
      prev = out_r;
      in_r = ~in_r;
      n    = 0;
      while (out_r == prev && n < 400) begin
         tick(1);
         n++;
      end
      chk({"req_lat_", tag}, n, SYNC + 2 + d);
      prev = out_a;
      in_a = ~in_a;
      n    = 0;
      while (out_a == prev && n < 20) begin
         tick(1);
         n++;
      end
      chk({"ack_lat_", tag}, n, SYNC + 1);
      exp_done++;
      chk({"done_", tag}, int'(done_cnt), exp_done % (1 << CW));
   endtask

   initial begin
      rst  = 1'b0;
      in_r = 1'b0;
      in_a = 1'b0;
      dly  = '0;

      // Back-to-back handshakes with delay 0, then one handshake with delay 5.
      // delay_cfg is changed to 99 after the request is accepted and must be ignored.
      vecs[0]  = '{1'b1, 1'b0, 8'd0,  3, 1'b0, 1'b0, 1'b1, 0, "b2b_r1_detect"};
      vecs[1]  = '{1'b1, 1'b0, 8'd0,  1, 1'b1, 1'b0, 1'b1, 0, "b2b_r1_out"};
      vecs[2]  = '{1'b1, 1'b1, 8'd0,  2, 1'b1, 1'b0, 1'b1, 0, "b2b_a1_sync"};
      vecs[3]  = '{1'b1, 1'b1, 8'd0,  1, 1'b1, 1'b1, 1'b0, 1, "b2b_a1_done"};
      vecs[4]  = '{1'b0, 1'b1, 8'd0,  4, 1'b0, 1'b1, 1'b1, 1, "b2b_r2_out"};
      vecs[5]  = '{1'b0, 1'b0, 8'd0,  3, 1'b0, 1'b0, 1'b0, 2, "b2b_a2_done"};
      vecs[6]  = '{1'b1, 1'b0, 8'd0,  4, 1'b1, 1'b0, 1'b1, 2, "b2b_r3_out"};
      vecs[7]  = '{1'b1, 1'b1, 8'd0,  3, 1'b1, 1'b1, 1'b0, 3, "b2b_a3_done"};
      vecs[8]  = '{1'b0, 1'b1, 8'd0,  4, 1'b0, 1'b1, 1'b1, 3, "b2b_r4_out"};
      vecs[9]  = '{1'b0, 1'b0, 8'd0,  3, 1'b0, 1'b0, 1'b0, 4, "b2b_a4_done"};
      vecs[10] = '{1'b1, 1'b0, 8'd5,  3, 1'b0, 1'b0, 1'b1, 4, "d5_busy"};
      vecs[11] = '{1'b1, 1'b0, 8'd99, 5, 1'b0, 1'b0, 1'b1, 4, "d5_wait"};
      vecs[12] = '{1'b1, 1'b0, 8'd99, 1, 1'b1, 1'b0, 1'b1, 4, "d5_out"};
      vecs[13] = '{1'b1, 1'b1, 8'd99, 3, 1'b1, 1'b1, 1'b0, 5, "d5_ack_done"};

      // Reset held while the inputs toggle: every output stays at its reset value.
      for (int i = 0; i < 6; i++) begin
         in_r = ~in_r;
         in_a = ~in_a;
         tick(1);
         chk("reset_hold_outs", int'({out_r, out_a, busy, err_ovr, err_ack, done_cnt}), 0);
      end
      do_reset();

      // Table-driven vectors.
      for (int i = 0; i < 14; i++) begin
         in_r = vecs[i].in_r;
         in_a = vecs[i].in_a;
         dly  = vecs[i].dly;
         tick(vecs[i].cycles);
         chk({vecs[i].name, "_outR"}, int'(out_r), int'(vecs[i].exp_out_r));
         chk({vecs[i].name, "_outA"}, int'(out_a), int'(vecs[i].exp_out_a));
         chk({vecs[i].name, "_busy"}, int'(busy), int'(vecs[i].exp_busy));
         chk({vecs[i].name, "_done"}, int'(done_cnt), vecs[i].exp_done);
         chk({vecs[i].name, "_errs"}, int'({err_ovr, err_ack}), 0);
      end
      exp_done = 5;

      // Exact latency at several delays, including the full-range delay.
      do_handshake(0, "d0");
      do_handshake(5, "d5");
      do_handshake(255, "d255");

      // Continue until done_cnt wraps past 2^CW-1.
      for (int i = 0; i < 10; i++) begin
         do_handshake(i % 3, "wrap");
      end
      chk("wrap_no_errs", int'({err_ovr, err_ack}), 0);

      // Overrun: a second inR toggle while the first handshake is still in progress.
      do_reset();
      dly  = 8'd10;
      in_r = 1'b1;
      tick(3);
      chk("ovr_busy", int'(busy), 1);
      in_r = 1'b0;
      tick(3);
      chk("ovr_flag", int'(err_ovr), 1);
      chk("ovr_outR_pending", int'(out_r), 0);
      tick(8);
      chk("ovr_first_outR", int'(out_r), 1);
      tick(10);
      chk("ovr_no_queue_outR", int'(out_r), 1);
      chk("ovr_no_queue_busy", int'(busy), 1);
      in_a = 1'b1;
      tick(3);
      chk("ovr_ack1_outA", int'(out_a), 1);
      chk("ovr_ack1_done", int'(done_cnt), 1);
      tick(1);
      chk("ovr_second_accept", int'(busy), 1);
      tick(10);
      chk("ovr_second_wait", int'(out_r), 1);
      tick(1);
      chk("ovr_second_outR", int'(out_r), 0);
      in_a = 1'b0;
      tick(3);
      chk("ovr_ack2_outA", int'(out_a), 0);
      chk("ovr_ack2_done", int'(done_cnt), 2);
      chk("ovr_idle", int'(busy), 0);
      chk("ovr_flags", int'({err_ovr, err_ack}), 2);

      // Spurious acks in IDLE and in WAIT_DLY are flagged and consumed.
      do_reset();
      in_a = 1'b1;
      tick(4);
      chk("spur_idle_flag", int'(err_ack), 1);
      chk("spur_idle_outA", int'(out_a), 0);
      chk("spur_idle_busy_done", int'({busy, done_cnt}), 0);
      dly  = 8'd10;
      in_r = 1'b1;
      tick(4);
      in_a = 1'b0;
      tick(3);
      chk("spur_dly_outs", int'({out_r, out_a, busy}), 1);
      tick(7);
      chk("spur_outR", int'(out_r), 1);
      tick(4);
      chk("spur_wait_ack_outA", int'(out_a), 0);
      chk("spur_wait_ack_busy", int'(busy), 1);
      in_a = 1'b1;
      tick(3);
      chk("spur_legit_outA", int'(out_a), 1);
      chk("spur_legit_done", int'(done_cnt), 1);
      chk("spur_flags", int'({err_ovr, err_ack}), 1);

      // Reset asserted in WAIT_ACK clears outputs without waiting for a clock edge.
      exp_done = 1;
      do_handshake(0, "pre_rst");
      dly  = 8'd0;
      in_r = ~in_r;
      tick(4);
      chk("mid_wait_ack_outR", int'(out_r), 1);
      chk("mid_wait_ack_busy", int'(busy), 1);
      #3;
      rst  = 1'b0;
      in_r = 1'b0;
      in_a = 1'b0;
      #1;
      chk("async_rst_outs", int'({out_r, out_a, busy, done_cnt}), 0);
      chk("async_rst_errs", int'({err_ovr, err_ack}), 0);
      tick(1);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("post_rst_quiet", int'({out_r, out_a, busy, done_cnt}), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
